// File: rtl/dport_pkg.sv
// Shared types for the data-port request master: op encodings, tag width
// and the entry kept per in-flight request.
package dport_pkg;

  localparam int TAG_W = 11;
  localparam int OUT_W = 5;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_INVAL = 2'd3
  } op_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_read;
  } pend_t;

  // A write with no byte enables carries nothing to the bus and is swallowed.
  function automatic logic is_dropped(op_e op, logic [3:0] be);
    return (op == OP_WRITE) && (be == 4'b0000);
  endfunction

endpackage

// File: rtl/dport_pend_fifo.sv
// In-order FIFO of pending request entries. A pop on empty is ignored and a
// push on full only lands when a pop frees the head slot in the same cycle.
module dport_pend_fifo
  import dport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  pend_t                        push_data_i,
  input  logic                         pop_i,
  output pend_t                        head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pend_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dport_req_master.sv
// Data-port initiator: accepts load/store/maintenance commands, issues them on
// mem_d_* with sequential tags, tracks them in order and strobes one response
// per ack.
//
// Handshakes: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; a bus request transfers on a rising edge where a
// request is presented and mem_d_accept_i is high, and until then address,
// data, strobes and tag are held; responses have no backpressure.
module dport_req_master
  import dport_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit CACHEABLE       = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_be_i,
  output logic [31:0]       mem_d_addr_o,
  output logic [31:0]       mem_d_data_wr_o,
  output logic              mem_d_rd_o,
  output logic [3:0]        mem_d_wr_o,
  output logic              mem_d_cacheable_o,
  output logic [TAG_W-1:0]  mem_d_req_tag_o,
  output logic              mem_d_flush_o,
  output logic              mem_d_invalidate_o,
  output logic              mem_d_writeback_o,
  input  logic              mem_d_accept_i,
  input  logic              mem_d_ack_i,
  input  logic              mem_d_error_i,
  input  logic [TAG_W-1:0]  mem_d_resp_tag_i,
  input  logic [31:0]       mem_d_data_rd_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_read_o,
  output logic              rsp_error_o,
  output logic [OUT_W-1:0]  outstanding_o,
  output logic              tag_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Request register
  logic              req_valid_q;
  logic [31:0]       req_addr_q;
  logic [31:0]       req_wdata_q;
  logic              req_rd_q;
  logic [3:0]        req_wr_q;
  logic              req_flush_q;
  logic              req_inval_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [TAG_W-1:0]  tag_cnt_q;

  // Response register
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_read_q, rsp_read_d;
  logic              rsp_error_q, rsp_error_d;
  logic              tag_err_q, tag_err_d;

  op_e               cmd_op;
  logic              cmd_fire, cmd_load;
  logic              bus_accept;
  logic              ack_hit, orphan_ack;
  logic [OUT_W-1:0]  inflight;
  logic [OUT_W:0]    budget_used;

  pend_t             push_entry, fifo_head;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign cmd_op = op_e'(cmd_op_i);

  // The FIFO occupancy is the in-flight count: an entry lives there from bus
  // accept until its ack.
  assign inflight    = OUT_W'(fifo_count);
  assign budget_used = {1'b0, inflight} + (OUT_W + 1)'(req_valid_q);

  // Ready needs a free request slot (or the current one leaving now) and room
  // in the budget; an ack in this cycle earns no credit.
  assign cmd_ready_o = !rst_i && (!req_valid_q || mem_d_accept_i)
                       && (budget_used < (OUT_W + 1)'(MAX_OUTSTANDING));
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_load    = cmd_fire && !is_dropped(cmd_op, cmd_be_i);

  assign bus_accept  = req_valid_q && mem_d_accept_i;
  assign ack_hit     = mem_d_ack_i && !fifo_empty;
  assign orphan_ack  = mem_d_ack_i && fifo_empty;

  // The budget keeps a slot free for every accepted request; the full guard
  // only keeps the FIFO self-consistent.
  assign push_entry  = '{tag: req_tag_q, is_read: req_rd_q};
  assign fifo_push   = bus_accept && (!fifo_full || ack_hit);

  dport_pend_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (mem_d_ack_i),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Load a request on command accept, retire it on bus accept; tags advance
  // only for commands that actually reach the bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= '0;
      req_flush_q <= 1'b0;
      req_inval_q <= 1'b0;
      req_tag_q   <= '0;
      tag_cnt_q   <= '0;
    end else if (cmd_load) begin
      req_valid_q <= 1'b1;
      req_addr_q  <= cmd_addr_i;
      req_wdata_q <= cmd_wdata_i;
      req_rd_q    <= (cmd_op == OP_READ);
      req_wr_q    <= (cmd_op == OP_WRITE) ? cmd_be_i : 4'b0000;
      req_flush_q <= (cmd_op == OP_FLUSH);
      req_inval_q <= (cmd_op == OP_INVAL);
      req_tag_q   <= tag_cnt_q;
      tag_cnt_q   <= tag_cnt_q + 1'b1;
    end else if (bus_accept) begin
      req_valid_q <= 1'b0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= '0;
      req_flush_q <= 1'b0;
      req_inval_q <= 1'b0;
    end
  end

  // Next response and protocol-error state from the ack and the FIFO head.
  always_comb begin
    rsp_valid_d = ack_hit;
    rsp_data_d  = '0;
    rsp_read_d  = 1'b0;
    rsp_error_d = 1'b0;
    if (ack_hit) begin
      rsp_data_d  = fifo_head.is_read ? mem_d_data_rd_i : 32'h0;
      rsp_read_d  = fifo_head.is_read;
      rsp_error_d = mem_d_error_i;
    end
    tag_err_d = tag_err_q || orphan_ack
                || (ack_hit && (mem_d_resp_tag_i != fifo_head.tag));
  end

  // Register the one-cycle response strobe and the sticky tag error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_read_q  <= 1'b0;
      rsp_error_q <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_read_q  <= rsp_read_d;
      rsp_error_q <= rsp_error_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign mem_d_addr_o       = req_addr_q;
  assign mem_d_data_wr_o    = req_wdata_q;
  assign mem_d_rd_o         = req_rd_q;
  assign mem_d_wr_o         = req_wr_q;
  assign mem_d_flush_o      = req_flush_q;
  assign mem_d_invalidate_o = req_inval_q;
  assign mem_d_req_tag_o    = req_tag_q;
  assign mem_d_cacheable_o  = CACHEABLE;
  assign mem_d_writeback_o  = 1'b0;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_read_o    = rsp_read_q;
  assign rsp_error_o   = rsp_error_q;
  assign outstanding_o = inflight;
  assign tag_err_o     = tag_err_q;

endmodule

// File: tb/tb_dport_req_master.sv
// Directed bench for dport_req_master with a behavioural data-port responder.
module tb_dport_req_master;
  import dport_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic [31:0] mem_d_addr_o, mem_d_data_wr_o;
  logic        mem_d_rd_o;
  logic [3:0]  mem_d_wr_o;
  logic        mem_d_cacheable_o;
  logic [10:0] mem_d_req_tag_o;
  logic        mem_d_flush_o, mem_d_invalidate_o, mem_d_writeback_o;
  logic        mem_d_accept_i, mem_d_ack_i, mem_d_error_i;
  logic [10:0] mem_d_resp_tag_i;
  logic [31:0] mem_d_data_rd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_read_o, rsp_error_o;
  logic [4:0]  outstanding_o;
  logic        tag_err_o;

  dport_req_master dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .mem_d_addr_o(mem_d_addr_o), .mem_d_data_wr_o(mem_d_data_wr_o),
    .mem_d_rd_o(mem_d_rd_o), .mem_d_wr_o(mem_d_wr_o),
    .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_flush_o(mem_d_flush_o), .mem_d_invalidate_o(mem_d_invalidate_o),
    .mem_d_writeback_o(mem_d_writeback_o), .mem_d_accept_i(mem_d_accept_i),
    .mem_d_ack_i(mem_d_ack_i), .mem_d_error_i(mem_d_error_i),
    .mem_d_resp_tag_i(mem_d_resp_tag_i), .mem_d_data_rd_i(mem_d_data_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_read_o(rsp_read_o),
    .rsp_error_o(rsp_error_o), .outstanding_o(outstanding_o), .tag_err_o(tag_err_o)
  );

  // ---------------- logs and responder controls ----------------
  typedef struct {
    logic [10:0] tag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  wr;
    int          cyc;
  } req_rec_t;

  typedef struct {
    logic [31:0] data;
    logic        rd;
    logic        err;
    int          cyc;
  } rsp_rec_t;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    int          rdy;
  } ack_ent_t;

  req_rec_t    req_log[$];
  rsp_rec_t    rsp_log[$];
  ack_ent_t    ack_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int cyc;
  bit acc_en, ack_en;
  int orphan_req_cnt, orphan_done_cnt;
  int bad_req_cnt, bad_done_cnt;

  int n_cmp, n_err;

  // Responder: accepts visible requests when enabled, acks in order no sooner
  // than the cycle after accept, and logs every response strobe.
  initial begin : responder
    req_rec_t    rr;
    rsp_rec_t    sr;
    ack_ent_t    ae;
    logic [31:0] wv;
    mem_d_accept_i   = 1'b0;
    mem_d_ack_i      = 1'b0;
    mem_d_error_i    = 1'b0;
    mem_d_resp_tag_i = '0;
    mem_d_data_rd_i  = '0;
    cyc              = 0;
    orphan_done_cnt  = 0;
    bad_done_cnt     = 0;
    mem_model[32'h100] = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) mem_model[32'h200 + 32'(4 * i)] = 32'hA0 + 32'(i);
    forever begin
      @(negedge clk);
      cyc++;
      mem_d_accept_i = 1'b0;
      if (acc_en && (mem_d_rd_o || (mem_d_wr_o != 4'b0) || mem_d_flush_o || mem_d_invalidate_o)) begin
        mem_d_accept_i = 1'b1;
        rr.tag = mem_d_req_tag_o; rr.addr = mem_d_addr_o; rr.wdata = mem_d_data_wr_o;
        rr.rd = mem_d_rd_o; rr.wr = mem_d_wr_o; rr.cyc = cyc;
        req_log.push_back(rr);
        if (mem_d_wr_o != 4'b0) begin
          wv = mem_model.exists(mem_d_addr_o) ? mem_model[mem_d_addr_o] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (mem_d_wr_o[b]) wv[8*b +: 8] = mem_d_data_wr_o[8*b +: 8];
          mem_model[mem_d_addr_o] = wv;
        end
        ae.tag  = mem_d_req_tag_o;
        ae.data = (mem_d_rd_o && mem_model.exists(mem_d_addr_o)) ? mem_model[mem_d_addr_o] : 32'h0;
        ae.rdy  = cyc + 1;
        ack_q.push_back(ae);
      end
      mem_d_ack_i = 1'b0; mem_d_error_i = 1'b0; mem_d_resp_tag_i = '0; mem_d_data_rd_i = '0;
      if (orphan_req_cnt != orphan_done_cnt) begin
        mem_d_ack_i = 1'b1;
        mem_d_resp_tag_i = 11'h7FF;
        orphan_done_cnt++;
      end else if (ack_en && ack_q.size() > 0 && ack_q[0].rdy <= cyc) begin
        ae = ack_q.pop_front();
        mem_d_ack_i = 1'b1;
        mem_d_resp_tag_i = ae.tag;
        mem_d_data_rd_i = ae.data;
        if (bad_req_cnt != bad_done_cnt) begin
          mem_d_resp_tag_i = ae.tag + 11'd1;
          bad_done_cnt++;
        end
      end
      if (rsp_valid_o) begin
        sr.data = rsp_data_o; sr.rd = rsp_read_o; sr.err = rsp_error_o; sr.cyc = cyc;
        rsp_log.push_back(sr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Mid-cycle sample point, after the responder has updated its inputs.
  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  // cmd_ready_o does not depend on the command inputs, so the command is only
  // presented once ready is seen high just before the transferring edge.
  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      sample();
      if (cmd_ready_o) ok = 1'b1;
    end
    check("cmd_accept", {31'b0, ok}, 32'd1);
    if (ok) begin
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr;
      cmd_wdata_i = wdata; cmd_be_i = be;
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget && rsp_log.size() < n; k++) sample();
    check("rsp_count", rsp_log.size(), n);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int rb, sb, wr_cnt;
    n_cmp = 0; n_err = 0;
    acc_en = 1'b0; ack_en = 1'b0;
    orphan_req_cnt = 0; bad_req_cnt = 0;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0;
    cmd_addr_i = '0; cmd_wdata_i = '0; cmd_be_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_addr", mem_d_addr_o, 0);
    check("rst_rd", mem_d_rd_o, 0);
    check("rst_wr", mem_d_wr_o, 0);
    check("rst_tag", mem_d_req_tag_o, 0);
    check("rst_flush_inval_wb", {mem_d_flush_o, mem_d_invalidate_o, mem_d_writeback_o}, 0);
    check("rst_cacheable", mem_d_cacheable_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_tag_err", tag_err_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sample();
    check("post_rst_ready", cmd_ready_o, 1);

    // Single read with 1-cycle ack
    acc_en = 1'b1; ack_en = 1'b1;
    rb = req_log.size(); sb = rsp_log.size();
    send(OP_READ, 32'h100, 32'h0, 4'h0);
    wait_rsp(sb + 1, 20);
    check("rd1_tag", req_log[rb].tag, 0);
    check("rd1_addr", req_log[rb].addr, 32'h100);
    check("rd1_strobes", {req_log[rb].rd, req_log[rb].wr}, 5'b10000);
    check("rd1_data", rsp_log[sb].data, 32'hDEADBEEF);
    check("rd1_read", rsp_log[sb].rd, 1);
    check("rd1_err", rsp_log[sb].err, 0);
    check("rd1_latency", rsp_log[sb].cyc - req_log[rb].cyc, 2);
    check("rd1_outstanding", outstanding_o, 0);

    // Partial write then read-back
    apply_reset();
    rb = req_log.size(); sb = rsp_log.size();
    send(OP_WRITE, 32'h104, 32'h11223344, 4'b0011);
    send(OP_READ, 32'h104, 32'h0, 4'h0);
    wait_rsp(sb + 2, 30);
    check("wr_tag", req_log[rb].tag, 0);
    check("wr_strobes", {req_log[rb].rd, req_log[rb].wr}, 5'b00011);
    check("wr_data", req_log[rb].wdata, 32'h11223344);
    check("rb_tag", req_log[rb+1].tag, 1);
    check("wr_rsp_data", rsp_log[sb].data, 0);
    check("wr_rsp_read", rsp_log[sb].rd, 0);
    check("rb_data", rsp_log[sb+1].data, 32'h00003344);
    check("rb_read", rsp_log[sb+1].rd, 1);

    // In-flight limit with acks withheld
    apply_reset();
    ack_en = 1'b0;
    rb = req_log.size(); sb = rsp_log.size();
    for (int i = 0; i < 4; i++) send(OP_READ, 32'h200 + 32'(4 * i), 32'h0, 4'h0);
    repeat (3) sample();
    check("lim_outstanding", outstanding_o, 4);
    check("lim_issued", req_log.size() - rb, 4);
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = 32'h210; cmd_be_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("lim_ready_low", cmd_ready_o, 0);
    end
    check("lim_still_issued", req_log.size() - rb, 4);
    ack_en = 1'b1;
    send(OP_READ, 32'h210, 32'h0, 4'h0);
    send(OP_READ, 32'h214, 32'h0, 4'h0);
    wait_rsp(sb + 6, 60);
    for (int i = 0; i < 6; i++) begin
      check("lim_tag", req_log[rb+i].tag, i);
      check("lim_data", rsp_log[sb+i].data, 32'hA0 + 32'(i));
    end

    // Accept withheld for 3 cycles
    apply_reset();
    acc_en = 1'b0;
    rb = req_log.size(); sb = rsp_log.size();
    send(OP_READ, 32'h300, 32'h0, 4'h0);
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = 32'h304; cmd_be_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("hold_addr", mem_d_addr_o, 32'h300);
      check("hold_rd", {mem_d_rd_o, mem_d_wr_o}, 5'b10000);
      check("hold_tag", mem_d_req_tag_o, 0);
      check("hold_ready", cmd_ready_o, 0);
    end
    acc_en = 1'b1;
    send(OP_READ, 32'h304, 32'h0, 4'h0);
    wait_rsp(sb + 2, 20);
    check("hold_first", req_log[rb].addr, 32'h300);
    check("hold_second", req_log[rb+1].addr, 32'h304);
    check("hold_second_tag", req_log[rb+1].tag, 1);

    // Tag mismatch and orphan ack
    apply_reset();
    rb = req_log.size(); sb = rsp_log.size();
    for (int i = 0; i < 4; i++) send(OP_READ, 32'h400 + 32'(4 * i), 32'h0, 4'h0);
    wait_rsp(sb + 4, 30);
    check("terr_clean", tag_err_o, 0);
    bad_req_cnt++;
    send(OP_READ, 32'h410, 32'h0, 4'h0);
    wait_rsp(sb + 5, 20);
    check("terr_head_tag", req_log[rb+4].tag, 4);
    check("terr_set", tag_err_o, 1);
    check("terr_rsp_read", rsp_log[sb+4].rd, 1);
    send(OP_READ, 32'h414, 32'h0, 4'h0);
    wait_rsp(sb + 6, 20);
    check("terr_sticky", tag_err_o, 1);
    apply_reset();
    sample();
    check("terr_cleared", tag_err_o, 0);
    sb = rsp_log.size();
    orphan_req_cnt++;
    repeat (4) sample();
    check("orphan_err", tag_err_o, 1);
    check("orphan_no_rsp", rsp_log.size(), sb);
    check("orphan_outstanding", outstanding_o, 0);

    // Long back-to-back stream through the tag wrap, with a dropped write
    apply_reset();
    rb = req_log.size(); sb = rsp_log.size();
    for (int i = 0; i < 2050; i++) begin
      send(OP_READ, 32'(4 * i), 32'h0, 4'h0);
      if (i == 1000) send(OP_WRITE, 32'h9000, 32'h55, 4'b0000);
    end
    wait_rsp(sb + 2050, 100);
    check("wrap_issued", req_log.size() - rb, 2050);
    wr_cnt = 0;
    for (int i = 0; i < 2050; i++) begin
      check("wrap_tag", req_log[rb+i].tag, i % 2048);
      if (req_log[rb+i].wr != 4'b0) wr_cnt++;
    end
    check("wrap_no_write", wr_cnt, 0);
    check("wrap_span", req_log[rb+2049].cyc - req_log[rb].cyc, 2050);
    check("wrap_tag_err", tag_err_o, 0);
    check("wrap_outstanding", outstanding_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dport_req_master.md
Name: dport_req_master

Overview:
- Data-port initiator that drives the mem_d_* request/response interface of the TCM memory model and core-side data memories.
- Takes load/store/maintenance commands over a valid/ready command port and issues them on mem_d_* with auto-generated 11-bit tags.
- Tracks outstanding requests in order and returns read data and status on a one-cycle response strobe.
- Used in tb_mul_compare and later benches as the stimulus master and checker for data-port responders.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests in flight (issued and not yet acked); 1..16.
- CACHEABLE, 1, constant value driven on mem_d_cacheable_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command consumed this cycle when high with cmd_valid_i
- cmd_op_i  in  2  0=read, 1=write, 2=flush, 3=invalidate
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- cmd_be_i  in  4  write byte enables
- mem_d_addr_o  out  32  request address
- mem_d_data_wr_o  out  32  write data
- mem_d_rd_o  out  1  read request
- mem_d_wr_o  out  4  byte write strobes
- mem_d_cacheable_o  out  1  equals CACHEABLE
- mem_d_req_tag_o  out  11  request tag
- mem_d_flush_o  out  1  flush request
- mem_d_invalidate_o  out  1  invalidate request
- mem_d_writeback_o  out  1  tied 0
- mem_d_accept_i  in  1  responder takes the request this cycle
- mem_d_ack_i  in  1  response valid
- mem_d_error_i  in  1  response error
- mem_d_resp_tag_i  in  11  response tag
- mem_d_data_rd_i  in  32  read data, valid with ack
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_data_o  out  32  read data; 0 for non-reads
- rsp_read_o  out  1  response belongs to a read
- rsp_error_o  out  1  mem_d_error_i captured with ack
- outstanding_o  out  5  in-flight count
- tag_err_o  out  1  sticky protocol error flag

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all outputs 0, except mem_d_cacheable_o, which equals CACHEABLE. Tag counter, in-flight count and FIFO are cleared. Reset mid-operation discards all pending state; later acks count as orphans.
- Request register: holds one request (req_valid_q). Once presented, addr, data, strobes and tag are held stable until mem_d_accept_i is sampled high.
- Command acceptance: cmd_ready_o = (!req_valid_q || mem_d_accept_i) && (outstanding_q + req_valid_q < MAX_OUTSTANDING). The ready term gives no credit for an ack in the same cycle.
- Issue timing: an accepted command appears on mem_d_* the next cycle. Back-to-back issue is sustained while the responder accepts every cycle and the in-flight budget allows.
- Op mapping:
  - read: mem_d_rd_o=1, mem_d_wr_o=0.
  - write: mem_d_wr_o=cmd_be_i.
  - flush and invalidate: assert their strobe only.
  - A write with cmd_be_i==0 is consumed and discarded: no bus request, no response, no tag used.
- Tags: an 11-bit counter is assigned at command accept and increments per issued request. It wraps 2047 to 0.
- On bus accept: push {tag, is_read} into the pending FIFO (depth MAX_OUTSTANDING) and increment outstanding_q.
- Response handling, in order:
  - On mem_d_ack_i, pop the FIFO head and decrement outstanding_q.
  - Accept and ack in the same cycle leave the count unchanged.
  - Next cycle: rsp_valid_o=1, rsp_data_o = head is_read ? mem_d_data_rd_i : 0, rsp_read_o = is_read, rsp_error_o = mem_d_error_i. Latency is 1 cycle from ack.
  - There is no response backpressure.
- Tag check: if mem_d_resp_tag_i differs from the head tag, set tag_err_o (sticky until reset) and still pop and respond.
- Orphan ack: an ack with an empty FIFO sets tag_err_o, with no pop and no rsp_valid_o.
- outstanding_o = outstanding_q, zero-extended.

Decomposition:
- Package dport_pkg: op encodings (OP_READ, OP_WRITE, OP_FLUSH, OP_INVAL), TAG_W=11, and the pending-entry struct {tag[10:0], is_read}.
- Sub-module dport_pend_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty/count, and a same-cycle push+pop safe at both full and empty.

Test Plan:
- Single read at 0x100 with the responder acking 1 cycle after accept and returning 0xDEADBEEF -> request tag 0, rsp_valid_o 2 cycles after issue, rsp_data_o=0xDEADBEEF, rsp_read_o=1.
- Write 0x11223344 to 0x104 with be=4'b0011, then read 0x104 -> mem_d_wr_o=4'b0011 on issue; the read response returns 0x00003344 over a zero-initialised memory; tags 0 and 1.
- MAX_OUTSTANDING=4, responder never acks, 6 reads offered -> exactly 4 issued, cmd_ready_o low with outstanding_o=4; releasing the acks drains in order and the remaining 2 then issue.
- mem_d_accept_i held low for 3 cycles -> address, strobes and tag stay constant; cmd_ready_o stays 0 until the accept.
- Responder returns tag 5 while the head tag is 4 -> tag_err_o=1 and stays set; the response is still produced. A spurious ack when idle also sets tag_err_o with no rsp_valid_o.
- 2050 back-to-back reads -> the tag sequence wraps 2047 to 0 without tag_err_o. A write with be=0 in the stream produces no bus request or response, and the following request does not skip a tag.
